// File: rtl/sram_banked_dualport_wrapper.sv
// Two-requestor SRAM built from word-interleaved single-port banks, with per-bank
// round-robin conflict arbitration, byte-enable writes and a 1- or 2-cycle read pipe.
module sram_banked_dualport_wrapper #(
  parameter int numWord     = 1024,
  parameter int numBit      = 32,
  parameter int numBanks    = 4,
  parameter int readLat     = 1,
  parameter int numWordAddr = $clog2(numWord),
  parameter int numBE       = numBit / 8
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   scan_en_in,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [numWordAddr-1:0] p0_addr,
  input  logic [numBit-1:0]      p0_wdata,
  input  logic [numBE-1:0]       p0_be,
  output logic                   p0_gnt,
  output logic                   p0_rvalid,
  output logic [numBit-1:0]      p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [numWordAddr-1:0] p1_addr,
  input  logic [numBit-1:0]      p1_wdata,
  input  logic [numBE-1:0]       p1_be,
  output logic                   p1_gnt,
  output logic                   p1_rvalid,
  output logic [numBit-1:0]      p1_rdata
);

  localparam int BankLog = $clog2(numBanks);
  localparam int BankW   = (BankLog > 0) ? BankLog : 1;
  localparam int numRow  = numWord / numBanks;
  localparam int RowW    = (numWordAddr - BankLog > 0) ? (numWordAddr - BankLog) : 1;

  logic [1:0]             req;
  logic [1:0]             we;
  logic [numWordAddr-1:0] addr  [2];
  logic [numBit-1:0]      wdata [2];
  logic [numBE-1:0]       be    [2];
  logic [BankW-1:0]       bank  [2];
  logic [RowW-1:0]        row   [2];
  logic [1:0]             gnt;
  logic [1:0]             acc_wr;
  logic [1:0]             acc_rd;
  logic                   conflict;

  logic [numBanks-1:0]    rr_q;
  logic [numBanks-1:0]    rr_d;
  logic [numBit-1:0]      mem_q [numBanks][numRow];
  logic [1:0]             s1_vld_q;
  logic [numBit-1:0]      s1_data_q [2];
  logic [1:0]             rvalid;
  logic [numBit-1:0]      rdata [2];

  assign req      = {p1_req, p0_req};
  assign we       = {p1_we, p0_we};
  assign addr[0]  = p0_addr;
  assign addr[1]  = p1_addr;
  assign wdata[0] = p0_wdata;
  assign wdata[1] = p1_wdata;
  assign be[0]    = p0_be;
  assign be[1]    = p1_be;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bank[p] = (numBanks > 1) ? addr[p][BankW-1:0] : '0;
      row[p]  = RowW'(addr[p] >> BankLog);
    end
  end

  // rr_q[b] = 1 means port 1 wins the next same-bank conflict on bank b
  assign conflict = req[0] & req[1] & (bank[0] == bank[1]);
  assign gnt[0]   = ~scan_en_in & req[0] & (~conflict | ~rr_q[bank[0]]);
  assign gnt[1]   = ~scan_en_in & req[1] & (~conflict |  rr_q[bank[1]]);
  assign acc_wr   = gnt & we;
  assign acc_rd   = gnt & ~we;

  always_comb begin
    rr_d = rr_q;
    if (conflict && !scan_en_in) rr_d[bank[0]] = gnt[0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  // Array contents survive reset, like the macro it models
  always_ff @(posedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < numBE; b++) begin
        if (acc_wr[p] && be[p][b]) mem_q[bank[p]][row[p]][8*b +: 8] <= wdata[p][8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_vld_q     <= '0;
      s1_data_q[0] <= '0;
      s1_data_q[1] <= '0;
    end else begin
      s1_vld_q <= acc_rd;
      for (int p = 0; p < 2; p++) begin
        if (acc_rd[p]) s1_data_q[p] <= mem_q[bank[p]][row[p]];
      end
    end
  end

  generate
    if (readLat == 2) begin : g_lat2
      logic [1:0]        s2_vld_q;
      logic [numBit-1:0] s2_data_q [2];

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          s2_vld_q     <= '0;
          s2_data_q[0] <= '0;
          s2_data_q[1] <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          for (int p = 0; p < 2; p++) begin
            if (s1_vld_q[p]) s2_data_q[p] <= s1_data_q[p];
          end
        end
      end

      assign rvalid   = s2_vld_q;
      assign rdata[0] = s2_data_q[0];
      assign rdata[1] = s2_data_q[1];
    end else begin : g_lat1
      assign rvalid   = s1_vld_q;
      assign rdata[0] = s1_data_q[0];
      assign rdata[1] = s1_data_q[1];
    end
  endgenerate

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];

endmodule

// File: tb/tb_sram_banked_dualport_wrapper.sv
// Directed bench: a readLat=1 and a readLat=2 instance share one stimulus stream; a flat
// word-addressed memory model with due-cycle read queues predicts outputs every cycle.
module tb_sram_banked_dualport_wrapper;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b0;
  logic        scan = 1'b0;
  logic [1:0]  req  = 2'b00;
  logic [1:0]  we   = 2'b00;
  logic [9:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];

  // index k = instance*2 + port; instance 0 is readLat=1, instance 1 is readLat=2
  logic [3:0]  gnt_w;
  logic [3:0]  rv_w;
  logic [31:0] rd_w [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sram_banked_dualport_wrapper #(.readLat(1)) u_lat1 (
    .CLK(CLK), .RSTN(RSTN), .scan_en_in(scan),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_be(be[0]),
    .p0_gnt(gnt_w[0]), .p0_rvalid(rv_w[0]), .p0_rdata(rd_w[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_be(be[1]),
    .p1_gnt(gnt_w[1]), .p1_rvalid(rv_w[1]), .p1_rdata(rd_w[1])
  );

  sram_banked_dualport_wrapper #(.readLat(2)) u_lat2 (
    .CLK(CLK), .RSTN(RSTN), .scan_en_in(scan),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_be(be[0]),
    .p0_gnt(gnt_w[2]), .p0_rvalid(rv_w[2]), .p0_rdata(rd_w[2]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_be(be[1]),
    .p1_gnt(gnt_w[3]), .p1_rvalid(rv_w[3]), .p1_rdata(rd_w[3])
  );

  task automatic chk(string nm, int idx, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h t=%0t", nm, idx, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         rq [4][$];
  logic [31:0] mmem [1024];
  logic [3:0]  fav;
  logic [31:0] last [4];
  logic [1:0]  preq;
  logic [1:0]  pgnt;
  logic [46:0] pfld [2];

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = '0;
    fav  = '0;
    preq = '0;
    pgnt = '0;
    for (int k = 0; k < 4; k++) last[k] = '0;
  end

  always @(negedge CLK) begin : model_cmp
    logic [1:0] eg;
    logic       cf;
    int         bk [2];
    rd_t        e;
    if (!RSTN) begin
      fav  = '0;
      preq = '0;
      for (int k = 0; k < 4; k++) begin
        rq[k].delete();
        last[k] = '0;
        chk("rst_rvalid", k, 64'(rv_w[k]), 64'd0);
        chk("rst_rdata", k, 64'(rd_w[k]), 64'd0);
      end
    end else begin
      bk[0] = int'(addr[0]) % 4;
      bk[1] = int'(addr[1]) % 4;
      cf    = req[0] && req[1] && (bk[0] == bk[1]);
      eg[0] = !scan && req[0] && (!cf || fav[bk[0]] == 1'b0);
      eg[1] = !scan && req[1] && (!cf || fav[bk[1]] == 1'b1);
      for (int k = 0; k < 4; k++) chk("gnt", k, 64'(gnt_w[k]), 64'(eg[k % 2]));
      for (int k = 0; k < 4; k++) begin
        if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
          last[k] = rq[k][0].data;
          void'(rq[k].pop_front());
          chk("rvalid", k, 64'(rv_w[k]), 64'd1);
        end else begin
          chk("rvalid", k, 64'(rv_w[k]), 64'd0);
        end
        chk("rdata", k, 64'(rd_w[k]), 64'(last[k]));
      end
      for (int p = 0; p < 2; p++) begin
        if (preq[p] && !pgnt[p] && req[p])
          chk("req_stable", p, 64'({we[p], addr[p], wdata[p], be[p]}), 64'(pfld[p]));
      end
      if (cf && !scan) fav[bk[0]] = eg[0];
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          if (we[p]) begin
            for (int j = 0; j < 4; j++)
              if (be[p][j]) mmem[addr[p]][8*j +: 8] = wdata[p][8*j +: 8];
          end else begin
            e.data = mmem[addr[p]];
            e.due  = cyc + 1;
            rq[p].push_back(e);
            e.due  = cyc + 2;
            rq[2 + p].push_back(e);
          end
        end
        pfld[p] = {we[p], addr[p], wdata[p], be[p]};
      end
      preq = req;
      pgnt = eg;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(int p, logic w, logic [9:0] a, logic [31:0] d, logic [3:0] e);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    be[p]    = e;
  endtask

  task automatic clr(int p);
    req[p] = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    logic [1:0]  gs [3];
    logic [31:0] sv [8];
    int          p0cnt;
    int          p1at;
    sv = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
           32'hA0000004, 32'hDE00BE00, 32'hA0000006, 32'hA0000007};
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wdata[p] = '0; be[p] = '0;
    end
    #1;
    for (int k = 0; k < 4; k++) chk("reset_out", k, {31'd0, rv_w[k], rd_w[k]}, 64'd0);
    step(); step();
    RSTN = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 10'(i), 32'hA0000000 + i, 4'hF);
      step();
    end
    clr(0);

    // write then read addr 5
    drive(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    #1 chk("t1_wgnt", 0, 64'(gnt_w[0]), 64'd1);
    step();
    drive(0, 1'b0, 10'd5, 32'h0, 4'h0);
    #1 chk("t1_rgnt", 0, 64'(gnt_w[0]), 64'd1);
    step();
    clr(0);
    #1 chk("t1_rd_lat1", 0, {31'd0, rv_w[0], rd_w[0]}, {31'd0, 1'b1, 32'hDEADBEEF});
    step();
    #1 chk("t1_pulse_end", 0, 64'(rv_w[0]), 64'd0);
    chk("t1_rd_lat2", 2, {31'd0, rv_w[2], rd_w[2]}, {31'd0, 1'b1, 32'hDEADBEEF});
    step();

    // byte mask, then an all-zero byte enable that must be a granted no-op
    drive(0, 1'b1, 10'd5, 32'h00000000, 4'b0101);
    step();
    drive(0, 1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000);
    #1 chk("be0_gnt", 0, 64'(gnt_w[0]), 64'd1);
    step();
    drive(0, 1'b0, 10'd5, 32'h0, 4'h0);
    step();
    clr(0);
    #1 chk("mask_rd", 0, {31'd0, rv_w[0], rd_w[0]}, {31'd0, 1'b1, 32'hDE00BE00});
    step(); step();

    // parallel banks 0 and 3
    drive(0, 1'b0, 10'd4, 32'h0, 4'h0);
    drive(1, 1'b0, 10'd7, 32'h0, 4'h0);
    #1 chk("par_gnt", 0, {62'd0, gnt_w[1], gnt_w[0]}, 64'd3);
    step();
    clr(0); clr(1);
    #1 chk("par_rd0", 0, {31'd0, rv_w[0], rd_w[0]}, {31'd0, 1'b1, 32'hA0000004});
    chk("par_rd1", 1, {31'd0, rv_w[1], rd_w[1]}, {31'd0, 1'b1, 32'hA0000007});
    step(); step();

    // same-bank conflict held 3 cycles
    drive(0, 1'b0, 10'd1, 32'h0, 4'h0);
    drive(1, 1'b0, 10'd5, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1 gs[i] = {gnt_w[1], gnt_w[0]};
      step();
    end
    clr(0); clr(1);
    chk("rr_c0", 0, 64'(gs[0]), 64'd1);
    chk("rr_c1", 1, 64'(gs[1]), 64'd2);
    chk("rr_c2", 2, 64'(gs[2]), 64'd1);
    step(); step(); step();

    // back-to-back stream; instance 1 pulses 2 cycles after each accept
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(0, 1'b0, 10'(i), 32'h0, 4'h0);
      else       clr(0);
      #1;
      if (i >= 2) chk("stream_lat2", i, {31'd0, rv_w[2], rd_w[2]}, {31'd0, 1'b1, sv[i-2]});
      else        chk("stream_pre", i, 64'(rv_w[2]), 64'd0);
      step();
    end
    step();

    // scan blocks new grants while an accepted read completes
    drive(0, 1'b0, 10'd2, 32'h0, 4'h0);
    step();
    scan = 1'b1;
    drive(0, 1'b0, 10'd3, 32'h0, 4'h0);
    drive(1, 1'b0, 10'd6, 32'h0, 4'h0);
    #1 chk("scan_gnt", 0, {62'd0, gnt_w[1], gnt_w[0]}, 64'd0);
    chk("scan_inflight1", 0, {31'd0, rv_w[0], rd_w[0]}, {31'd0, 1'b1, 32'hA0000002});
    step();
    #1 chk("scan_gnt", 1, {62'd0, gnt_w[1], gnt_w[0]}, 64'd0);
    chk("scan_inflight2", 2, {31'd0, rv_w[2], rd_w[2]}, {31'd0, 1'b1, 32'hA0000002});
    step();
    scan = 1'b0;
    #1 chk("scan_release", 0, {62'd0, gnt_w[1], gnt_w[0]}, 64'd3);
    step();
    clr(0); clr(1);
    step(); step(); step();

    // reset with a read in flight
    drive(0, 1'b0, 10'd4, 32'h0, 4'h0);
    step();
    clr(0);
    RSTN = 1'b0;
    #1 chk("rst_fl_lat1", 0, {31'd0, rv_w[0], rd_w[0]}, 64'd0);
    step();
    #1 chk("rst_fl_lat2", 2, {31'd0, rv_w[2], rd_w[2]}, 64'd0);
    step();
    RSTN = 1'b1;
    step();
    #1 chk("post_rst_rdata", 0, 64'(rd_w[0]), 64'd0);
    drive(0, 1'b0, 10'd5, 32'h0, 4'h0);
    step();
    clr(0);
    #1 chk("post_rst_read", 0, {31'd0, rv_w[0], rd_w[0]}, {31'd0, 1'b1, 32'hDE00BE00});
    step(); step();

    // p0 camps on bank 1; p1 arrives one cycle later and must still get in
    p0cnt = 0;
    p1at  = -1;
    drive(0, 1'b0, 10'd1, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) drive(1, 1'b1, 10'd9, 32'h99990009, 4'hF);
      if (i == 3) clr(1);
      #1;
      if (gnt_w[0]) p0cnt++;
      if (req[1] && gnt_w[1] && p1at < 0) p1at = i;
      step();
    end
    clr(0);
    chk("starve_p1_at", 0, 64'(p1at), 64'd2);
    chk("starve_p0_cnt", 0, 64'(p0cnt), 64'd5);
    step(); step();
    drive(0, 1'b0, 10'd9, 32'h0, 4'h0);
    step();
    clr(0);
    #1 chk("starve_wr_rd", 0, {31'd0, rv_w[0], rd_w[0]}, {31'd0, 1'b1, 32'h99990009});
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
